// File: rtl/dsd_mod.sv
// Second-order delta-sigma modulator: signed PCM in, 1-bit DSD out, one bit every DIV+1 clocks.
// Latency 1 clk from tick sample to dsd; free-running, no backpressure. DSD_DITHER_EN adds LFSR dither.
`ifndef PCM_QUANT
`define PCM_QUANT 16
`endif

module dsd_mod #(
  parameter int PCM_W = `PCM_QUANT,
  parameter int DIV   = 0,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PCM_W-1:0] x,
  input  logic                    ovl_clr,
  output logic                    dsd,
  output logic                    dsd_stb,
  output logic                    ovl
);

  localparam int W  = PCM_W + GUARD;
  localparam int SW = W + 2;
  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  localparam logic signed [SW-1:0] FS_P  = {{(SW-PCM_W){1'b0}}, 1'b1, {(PCM_W-1){1'b0}}};
  localparam logic signed [SW-1:0] FS_N  = -FS_P;
  localparam logic signed [SW-1:0] I_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] I_MIN = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [SW-1:0] ZERO  = '0;

  logic [CW-1:0]        div_cnt_q, div_cnt_d;
  logic signed [W-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic                 dsd_q, dsd_d, stb_q, stb_d, ovl_q, ovl_d;
  logic                 tick, clamp;
  logic signed [SW-1:0] fb, x_e, s1, s1_sat, s2, s2_sat, d_e, q_sum;

`ifdef DSD_DITHER_EN
  logic [15:0]          lfsr_q, lfsr_d;
  logic signed [SW-1:0] d_raw;

  // Dither only biases the quantizer decision; it never enters the integrators.
  always_comb begin
    d_raw  = {{(SW-4){lfsr_q[3]}}, lfsr_q[3:0]};
    d_e    = d_raw <<< (PCM_W - 6);
    lfsr_d = tick ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign d_e = '0;
`endif

  always_comb begin
    tick      = (div_cnt_q == CW'(DIV));
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    fb        = dsd_q ? FS_P : FS_N;
    x_e       = {{(SW-PCM_W){x[PCM_W-1]}}, x};
    s1        = {{2{i1_q[W-1]}}, i1_q} + x_e - fb;
    s1_sat    = (s1 > I_MAX) ? I_MAX : ((s1 < I_MIN) ? I_MIN : s1);
    s2        = {{2{i2_q[W-1]}}, i2_q} + s1_sat - fb;
    s2_sat    = (s2 > I_MAX) ? I_MAX : ((s2 < I_MIN) ? I_MIN : s2);
    q_sum     = s2_sat + d_e;
    clamp     = (s1 != s1_sat) || (s2 != s2_sat);
    i1_d      = i1_q;
    i2_d      = i2_q;
    dsd_d     = dsd_q;
    if (tick) begin
      i1_d  = s1_sat[W-1:0];
      i2_d  = s2_sat[W-1:0];
      dsd_d = (q_sum >= ZERO);
    end
    stb_d = tick;
    // A clamp in the same cycle as a clear keeps the flag set.
    ovl_d = (tick && clamp) ? 1'b1 : (ovl_clr ? 1'b0 : ovl_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      dsd_q     <= 1'b0;
      stb_q     <= 1'b0;
      ovl_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      dsd_q     <= dsd_d;
      stb_q     <= stb_d;
      ovl_q     <= ovl_d;
    end
  end

  assign dsd     = dsd_q;
  assign dsd_stb = stb_q;
  assign ovl     = ovl_q;

endmodule
